// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: machine width,
// reset/increment defaults, fetch FSM encoding and address helpers.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handoff.
// master = fetch controller side, slave = memory/decode environment side.
interface pc_fetch_ctrl_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface

// File: rtl/alu_adder.sv
// Plain unsigned adder, wraps modulo 2^WIDTH.
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] adder_inp1,
  input  logic [WIDTH-1:0] adder_inp2,
  output logic [WIDTH-1:0] adder_out
);

  assign adder_out = adder_inp1 + adder_inp2;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: issues one instruction-memory request at a time,
// hands the fetched word to decode and handles branch/jump redirects.
// Data for a request that was overtaken by a redirect is never presented.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] PC_INC   = mips_pkg::PC_INC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [mips_pkg::XLEN-1:0] branch_target,
  input  logic                      jump,
  input  logic [mips_pkg::XLEN-1:0] jump_target,
  pc_fetch_ctrl_if.master           bus
);
  import mips_pkg::*;

  fetch_state_t    state_p0, state_nxt;
  logic [XLEN-1:0] pc_p0, pc_nxt;
  logic [XLEN-1:0] pc_inc;
  logic            req_p0, req_nxt;
  logic [XLEN-1:0] addr_p0, addr_nxt;
  logic [XLEN-1:0] instr_p0, instr_nxt;
  logic [XLEN-1:0] ipc_p0, ipc_nxt;
  logic            vld_p0, vld_nxt;

  logic            redir;
  logic [XLEN-1:0] redir_target;
  logic [XLEN-1:0] fetch_addr;

  alu_adder #(.WIDTH(XLEN)) u_pc_adder (
    .adder_inp1 (pc_p0),
    .adder_inp2 (PC_INC),
    .adder_out  (pc_inc)
  );

  // Branch wins over jump; the next fetch address is the target on a redirect.
  assign redir        = branch_taken | jump;
  assign redir_target = word_align(branch_taken ? branch_target : jump_target);
  assign fetch_addr   = redir ? redir_target : pc_p0;

  // Next-state and next-output decode for the fetch FSM.
  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    req_nxt   = req_p0;
    addr_nxt  = addr_p0;
    instr_nxt = instr_p0;
    ipc_nxt   = ipc_p0;
    vld_nxt   = vld_p0;
    case (state_p0)
      IDLE: begin
        req_nxt = 1'b0;
        if (redir) pc_nxt = redir_target;
        if (!stall) begin
          state_nxt = FETCH;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_addr;
          pc_nxt    = fetch_addr;
        end
      end
      FETCH: begin
        if (bus.imem_ack) begin
          if (redir) begin
            // Returned word belongs to the old path: drop it, refetch at target.
            pc_nxt   = redir_target;
            addr_nxt = redir_target;
            req_nxt  = 1'b1;
          end else begin
            instr_nxt = bus.imem_rdata;
            ipc_nxt   = addr_p0;
            vld_nxt   = 1'b1;
            pc_nxt    = pc_inc;
            req_nxt   = 1'b0;
            state_nxt = HOLD;
          end
        end else if (redir) begin
          // Request still in flight; it must complete before the new one.
          pc_nxt    = redir_target;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (redir) pc_nxt = redir_target;
        if (bus.imem_ack) begin
          state_nxt = FETCH;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_addr;
          pc_nxt    = fetch_addr;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_nxt    = redir_target;
          vld_nxt   = 1'b0;
          state_nxt = FETCH;
          req_nxt   = 1'b1;
          addr_nxt  = redir_target;
        end else if (bus.instr_ready && !stall) begin
          vld_nxt   = 1'b0;
          state_nxt = FETCH;
          req_nxt   = 1'b1;
          addr_nxt  = pc_p0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset returns to IDLE at RESET_PC at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      pc_p0    <= RESET_PC;
      req_p0   <= 1'b0;
      addr_p0  <= RESET_PC;
      instr_p0 <= '0;
      ipc_p0   <= '0;
      vld_p0   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      pc_p0    <= pc_nxt;
      req_p0   <= req_nxt;
      addr_p0  <= addr_nxt;
      instr_p0 <= instr_nxt;
      ipc_p0   <= ipc_nxt;
      vld_p0   <= vld_nxt;
    end
  end

  assign bus.imem_req    = req_p0;
  assign bus.imem_addr   = addr_p0;
  assign bus.instr       = instr_p0;
  assign bus.instr_pc    = ipc_p0;
  assign bus.instr_valid = vld_p0;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a request/instruction scoreboard.
module tb_pc_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_instr_t;

  logic        clk;
  logic        rst_n, rst_n2;
  logic        stall, stall2;
  logic        branch_taken, jump;
  logic [31:0] branch_target, jump_target;

  pc_fetch_ctrl_if bus ();
  pc_fetch_ctrl_if bus2 ();

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .bus           (bus)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(32'd4)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n2),
    .stall         (stall2),
    .branch_taken  (1'b0),
    .branch_target (32'h0),
    .jump          (1'b0),
    .jump_target   (32'h0),
    .bus           (bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_req2  = 0;
  int n_ack2  = 0;
  int ack_delay = 2;
  int auto_resp = 1;
  int man_ack_cnt = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_addr2[$];
  exp_instr_t  exp_instr[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_valid(input int target);
    int i = 0;
    while (n_valid < target && i < 300) begin
      step();
      i++;
    end
    chk("wait_valid", 32'(n_valid), 32'(target));
  endtask

  task automatic push_instr(input logic [31:0] pc, input logic [31:0] data);
    exp_instr_t e;
    e.pc   = pc;
    e.data = data;
    exp_instr.push_back(e);
  endtask

  // Memory responder for the main DUT: ack ack_delay cycles after a request.
  initial begin
    int cnt = 0;
    bit busy = 0;
    int man_seen = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || auto_resp == 0) begin
        busy = 0;
        if (man_ack_cnt != man_seen && !bus.imem_ack) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = 32'hDEAD_BEEF;
          man_seen       = man_ack_cnt;
        end else begin
          bus.imem_ack = 1'b0;
        end
      end else begin
        if (bus.imem_ack) begin
          bus.imem_ack = 1'b0;
          busy = 0;
        end
        if (!busy && bus.imem_req) begin
          busy = 1;
          cnt  = ack_delay;
        end else if (busy) begin
          cnt--;
        end
        if (busy && cnt == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};
        end
      end
    end
  end

  // Memory responder for the wrap-around DUT: immediate ack, three requests only.
  initial begin
    bus2.imem_ack   = 1'b0;
    bus2.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n2 || bus2.imem_ack) begin
        bus2.imem_ack = 1'b0;
      end else if (bus2.imem_req && n_ack2 < 3) begin
        bus2.imem_ack   = 1'b1;
        bus2.imem_rdata = {16'hBEEF, bus2.imem_addr[15:0]};
        n_ack2++;
      end
    end
  end

  // Scoreboard monitor for the main DUT.
  initial begin
    logic prev_req = 1'b0;
    logic prev_vld = 1'b0;
    exp_instr_t e;
    forever begin
      @(negedge clk);
      if (bus.imem_req && (!prev_req || bus.imem_ack)) begin
        if (exp_addr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: addr 0x%08h, no request expected", bus.imem_addr);
        end else begin
          chk("imem_addr", bus.imem_addr, exp_addr.pop_front());
        end
      end
      if (bus.instr_valid && !prev_vld) begin
        n_valid++;
        chk("valid_after_ack", 32'(bus.imem_ack), 32'd1);
        if (exp_instr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: pc 0x%08h instr 0x%08h, none expected",
                   bus.instr_pc, bus.instr);
        end else begin
          e = exp_instr.pop_front();
          chk("instr_pc", bus.instr_pc, e.pc);
          chk("instr", bus.instr, e.data);
        end
      end
      prev_req = bus.imem_req;
      prev_vld = bus.instr_valid;
    end
  end

  // Address monitor for the wrap-around DUT.
  initial begin
    logic prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus2.imem_req && (!prev_req || bus2.imem_ack)) begin
        n_req2++;
        if (exp_addr2.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req2: addr 0x%08h, no request expected", bus2.imem_addr);
        end else begin
          chk("wrap_imem_addr", bus2.imem_addr, exp_addr2.pop_front());
        end
      end
      prev_req = bus2.imem_req;
    end
  end

  initial begin
    rst_n = 1'b0;
    rst_n2 = 1'b0;
    stall = 1'b0;
    stall2 = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    jump = 1'b0;
    jump_target = 32'h0;
    bus.instr_ready = 1'b1;
    bus2.instr_ready = 1'b1;
    repeat (2) step();

    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst2_addr", bus2.imem_addr, 32'hFFFF_FFFC);

    // Sequential fetch 0x0, 0x4, 0x8 with ack two cycles after each request.
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    push_instr(32'h0, 32'hC0DE_0000);
    push_instr(32'h4, 32'hC0DE_0004);
    push_instr(32'h8, 32'hC0DE_0008);
    exp_addr2.push_back(32'hFFFF_FFFC);
    exp_addr2.push_back(32'h0000_0000);
    exp_addr2.push_back(32'h0000_0004);
    exp_addr2.push_back(32'h0000_0008);
    rst_n = 1'b1;
    rst_n2 = 1'b1;
    wait_valid(3);
    stall = 1'b1;

    // HOLD must keep the word steady and issue nothing while stalled / not ready.
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        stall = 1'b0;
        bus.instr_ready = 1'b0;
      end
      step();
      chk("hold_instr", bus.instr, 32'hC0DE_0008);
      chk("hold_instr_pc", bus.instr_pc, 32'h8);
      chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold_req", 32'(bus.imem_req), 32'd0);
    end

    // Branch while request 0xC is outstanding; its data must be discarded.
    exp_addr.push_back(32'hC);
    exp_addr.push_back(32'h100);
    push_instr(32'h100, 32'hC0DE_0100);
    ack_delay = 3;
    bus.instr_ready = 1'b1;
    step();
    branch_taken = 1'b1;
    branch_target = 32'h100;
    bus.instr_ready = 1'b0;
    step();
    branch_taken = 1'b0;
    chk("flush_req", 32'(bus.imem_req), 32'd1);
    chk("flush_addr", bus.imem_addr, 32'hC);
    wait_valid(4);

    // Branch and jump together: branch target wins.
    exp_addr.push_back(32'h200);
    push_instr(32'h200, 32'hC0DE_0200);
    ack_delay = 2;
    branch_taken = 1'b1;
    branch_target = 32'h200;
    jump = 1'b1;
    jump_target = 32'h300;
    step();
    branch_taken = 1'b0;
    jump = 1'b0;
    chk("redir_valid_drop", 32'(bus.instr_valid), 32'd0);
    wait_valid(5);

    // Jump alone with unaligned target, issued under stall.
    exp_addr.push_back(32'h300);
    push_instr(32'h300, 32'hC0DE_0300);
    stall = 1'b1;
    jump = 1'b1;
    jump_target = 32'h303;
    step();
    jump = 1'b0;
    wait_valid(6);
    stall = 1'b0;

    // Redirect in the same cycle as the ack: word dropped, refetch at target.
    exp_addr.push_back(32'h304);
    exp_addr.push_back(32'h400);
    push_instr(32'h400, 32'hC0DE_0400);
    ack_delay = 0;
    bus.instr_ready = 1'b1;
    step();
    jump = 1'b1;
    jump_target = 32'h400;
    bus.instr_ready = 1'b0;
    step();
    jump = 1'b0;
    wait_valid(7);
    ack_delay = 2;

    // Reset in the middle of a fetch, then a stray ack while idle.
    exp_addr.push_back(32'h404);
    ack_delay = 3;
    bus.instr_ready = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(bus.imem_req), 32'd0);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("midrst_instr", bus.instr, 32'h0);
    bus.instr_ready = 1'b0;
    stall = 1'b1;
    step();
    step();
    auto_resp = 0;
    rst_n = 1'b1;
    step();
    man_ack_cnt++;
    repeat (3) step();
    chk("stray_ack_valid", 32'(bus.instr_valid), 32'd0);
    chk("stray_ack_req", 32'(bus.imem_req), 32'd0);
    exp_addr.push_back(32'h0);
    push_instr(32'h0, 32'hC0DE_0000);
    ack_delay = 2;
    auto_resp = 1;
    stall = 1'b0;
    wait_valid(8);

    for (int i = 0; i < 100 && n_req2 < 4; i++) step();
    chk("wrap_req_count", 32'(n_req2), 32'd4);
    repeat (3) step();
    chk("addr_queue_left", 32'(exp_addr.size()), 32'd0);
    chk("instr_queue_left", 32'(exp_instr.size()), 32'd0);
    chk("addr2_queue_left", 32'(exp_addr2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_INC, 4, sequential PC increment.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall; freezes PC advance.
- branch_taken  in  1  branch redirect request.
- branch_target  in  32  branch redirect address.
- jump  in  1  jump redirect request.
- jump_target  in  32  jump redirect address.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request address.
- imem_ack  in  1  read complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched word.
- instr  out  32  fetched instruction to decode.
- instr_pc  out  32  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts instr.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have four states: IDLE, FETCH, FLUSH, HOLD. All outputs SHALL be registered.
REQ-005 IDLE: imem_req=0. Next state is FETCH when stall=0; otherwise the FSM stays in IDLE.
REQ-006 On entering FETCH, imem_addr SHALL latch pc. imem_req=1 with imem_addr stable until the imem_ack cycle.
REQ-007 FETCH with imem_ack=1 and no redirect:
- instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1.
- pc<=pc+PC_INC.
- Next state HOLD; imem_req deasserts in the next cycle.
- Latency: ack in cycle N gives instr_valid=1 in cycle N+1.
REQ-008 HOLD: instr_valid=1 with instr/instr_pc stable. When instr_ready=1 and stall=0, instr_valid<=0 and the next state is FETCH. Otherwise the FSM stays in HOLD.
REQ-009 Redirect is defined as redir = branch_taken | jump. The target SHALL be branch_target when branch_taken=1, else jump_target; branch_taken wins over jump. Target bits [1:0] SHALL be forced to 0.
REQ-010 Redirect handling per state:
- IDLE: pc<=target.
- HOLD: pc<=target, instr_valid<=0, next state FETCH.
- FETCH with imem_ack=1: discard rdata (instr_valid stays 0), pc<=target, next state FETCH with a new address.
- FETCH with imem_ack=0: pc<=target, next state FLUSH.
REQ-011 FLUSH: imem_req=1 with the old imem_addr held. On imem_ack, rdata SHALL be discarded and the next state is FETCH. A further redirect in FLUSH SHALL overwrite pc.
REQ-012 PC arithmetic SHALL be unsigned 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-013 stall SHALL NOT abort an outstanding request. A redirect SHALL take effect even when stall=1.
REQ-014 instr_valid SHALL never be asserted for data whose request preceded a redirect.

Reset
REQ-015 While rst_n=0, with effect immediate and asynchronous:
- state=IDLE, pc=RESET_PC, imem_addr=RESET_PC.
- imem_req=0, instr=0, instr_pc=0, instr_valid=0.
REQ-016 Reset during FETCH/FLUSH SHALL drop imem_req at once. An imem_ack arriving after reset release without a new request SHALL be ignored.

Structure
REQ-017 The shared package mips_pkg SHALL hold XLEN=32, RESET_PC, PC_INC and the FSM state encoding.
REQ-018 The pc+PC_INC increment SHALL be one instance of the existing alu_adder with adder_inp2=PC_INC. No other sub-modules SHALL be used.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release, stall=0, imem_ack 2 cycles after req, instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; instr_valid one cycle after each ack.
- branch_taken=1, branch_target=0x100 while in FETCH without ack; ack 3 cycles later -> that data is never valid; next imem_addr=0x100.
- branch_taken=1 (0x200) and jump=1 (0x300) in the same cycle -> next fetch 0x200. jump_target=0x303 alone -> fetch 0x300.
- RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000.
- HOLD with instr_ready=0 or stall=1 for 5 cycles -> instr/instr_pc stable, no new imem_req.
- rst_n low mid-FETCH -> imem_req=0 in the same cycle; after release the first fetch is RESET_PC.
